// File: rtl/viterbi_pkg.sv
// Shared Viterbi definitions: normalisation modes, clog2 and the lane-packing helper.
// Lane i of a packed metric bus sits at bits [lane_lsb(i, w) +: w].
package viterbi_pkg;

  localparam int NORM_MIN    = 0;
  localparam int NORM_THRESH = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/pm_min_tree.sv
// Combinational balanced argmin tree over NUM_STATES packed lanes.
// Ties resolve to the lowest lane index because the left child is kept unless the right is strictly smaller.
module pm_min_tree
  import viterbi_pkg::*;
#(
  parameter  int NUM_STATES = 4,
  parameter  int PM_W       = 4,
  localparam int IDX_W      = clog2(NUM_STATES)
) (
  input  logic [NUM_STATES*PM_W-1:0] lanes,
  output logic [PM_W-1:0]            min_val,
  output logic [IDX_W-1:0]           min_idx
);

  for (genvar l = 0; l <= IDX_W; l++) begin : g_lvl
    localparam int N = NUM_STATES >> l;
    logic [PM_W-1:0]  val [N];
    logic [IDX_W-1:0] idx [N];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_in
        assign val[i] = lanes[lane_lsb(i, PM_W) +: PM_W];
        assign idx[i] = IDX_W'(i);
      end
    end else begin : g_node
      for (genvar i = 0; i < N; i++) begin : g_cmp
        logic take_right_s;
        assign take_right_s = g_lvl[l-1].val[2*i+1] < g_lvl[l-1].val[2*i];
        assign val[i] = take_right_s ? g_lvl[l-1].val[2*i+1] : g_lvl[l-1].val[2*i];
        assign idx[i] = take_right_s ? g_lvl[l-1].idx[2*i+1] : g_lvl[l-1].idx[2*i];
      end
    end
  end

  assign min_val = g_lvl[IDX_W].val[0];
  assign min_idx = g_lvl[IDX_W].idx[0];

endmodule

// File: rtl/pm_store_norm.sv
// Path-metric store for the Viterbi decoder: registers normalised ACS metrics,
// tracks the best state and a sticky saturation flag.
module pm_store_norm
  import viterbi_pkg::*;
#(
  parameter  int          NUM_STATES = 4,
  parameter  int          PM_W       = 4,
  parameter  int          NORM_MODE  = NORM_MIN,
  parameter  int unsigned INIT_PEN   = (32'd1 << PM_W) - 32'd1,
  localparam int          IDX_W      = clog2(NUM_STATES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       npm_valid,
  input  logic [NUM_STATES*PM_W-1:0] npm,
  output logic [NUM_STATES*PM_W-1:0] pm,
  output logic                       pm_valid,
  output logic [IDX_W-1:0]           best_state,
  output logic                       norm_event,
  output logic                       sat
);

  localparam logic [PM_W-1:0] HALF      = {1'b1, {(PM_W-1){1'b0}}};
  localparam logic [PM_W-1:0] INIT_LANE = PM_W'(INIT_PEN);

  logic [PM_W-1:0]            npm_min_s;
  logic [IDX_W-1:0]           npm_min_idx_unused_s;
  logic [PM_W-1:0]            best_min_unused_s;
  logic [IDX_W-1:0]           best_idx_s;
  logic                       all_msb_s;
  logic                       sat_hit_s;
  logic [PM_W-1:0]            sub_s;
  logic [NUM_STATES*PM_W-1:0] sub_lanes_s;

  logic [NUM_STATES*PM_W-1:0] pm_d, pm_q;
  logic [IDX_W-1:0]           best_d, best_q;
  logic                       pm_valid_d, pm_valid_q;
  logic                       norm_event_d, norm_event_q;
  logic                       sat_d, sat_q;

  pm_min_tree #(.NUM_STATES(NUM_STATES), .PM_W(PM_W)) u_npm_min (
    .lanes   (npm),
    .min_val (npm_min_s),
    .min_idx (npm_min_idx_unused_s)
  );

  // The same tree shape runs on the normalised lanes so best_state matches the stored metrics.
  pm_min_tree #(.NUM_STATES(NUM_STATES), .PM_W(PM_W)) u_best_min (
    .lanes   (sub_lanes_s),
    .min_val (best_min_unused_s),
    .min_idx (best_idx_s)
  );

  always_comb begin
    all_msb_s   = 1'b1;
    sat_hit_s   = 1'b0;
    sub_lanes_s = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      all_msb_s = all_msb_s & npm[lane_lsb(i, PM_W) + PM_W - 1];
      sat_hit_s = sat_hit_s | (npm[lane_lsb(i, PM_W) +: PM_W] == {PM_W{1'b1}});
    end
    if (NORM_MODE == NORM_MIN) begin
      sub_s = npm_min_s;
    end else begin
      sub_s = all_msb_s ? HALF : {PM_W{1'b0}};
    end
    // sub never exceeds any lane in either mode, so no lane can wrap.
    for (int i = 0; i < NUM_STATES; i++) begin
      sub_lanes_s[lane_lsb(i, PM_W) +: PM_W] = npm[lane_lsb(i, PM_W) +: PM_W] - sub_s;
    end
  end

  always_comb begin
    pm_d         = pm_q;
    best_d       = best_q;
    sat_d        = sat_q;
    pm_valid_d   = 1'b0;
    norm_event_d = 1'b0;
    if (start) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_d[lane_lsb(i, PM_W) +: PM_W] = (i == 0) ? {PM_W{1'b0}} : INIT_LANE;
      end
      best_d = '0;
      sat_d  = 1'b0;
    end else if (npm_valid) begin
      pm_d         = sub_lanes_s;
      best_d       = best_idx_s;
      sat_d        = sat_q | sat_hit_s;
      pm_valid_d   = 1'b1;
      norm_event_d = (sub_s != {PM_W{1'b0}});
    end else begin
      pm_d = pm_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pm_q         <= '0;
      best_q       <= '0;
      pm_valid_q   <= 1'b0;
      norm_event_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      pm_q         <= pm_d;
      best_q       <= best_d;
      pm_valid_q   <= pm_valid_d;
      norm_event_q <= norm_event_d;
      sat_q        <= sat_d;
    end
  end

  assign pm         = pm_q;
  assign best_state = best_q;
  assign pm_valid   = pm_valid_q;
  assign norm_event = norm_event_q;
  assign sat        = sat_q;

endmodule

// File: doc/pm_store_norm.md
# pm_store_norm

Parametrised path-metric storage for the Viterbi decoder, sitting between the add-compare-select array and traceback. It registers one new path metric per trellis state per accepted symbol and normalises the metrics so they never wrap. It also reports the best (minimum-metric) state for traceback start and keeps a sticky saturation flag. It generalises the fixed four-state, 4-bit store to any power-of-two state count, any metric width and two normalisation modes.

## Interface
- NUM_STATES, 4: trellis states; power of two, 2..64
- PM_W, 4: path-metric width in bits, 3..16
- NORM_MODE, 0: 0 = subtract minimum on every update; 1 = subtract 2^(PM_W-1) when all metric MSBs are set
- INIT_PEN, 2^PM_W-1: metric loaded into states 1..NUM_STATES-1 on `start`
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  sync pulse: load known-start metrics (new frame)
- npm_valid  in  1  npm bus holds a new metric set this cycle
- npm  in  NUM_STATES*PM_W  new metrics from ACS; state i at bits [i*PM_W +: PM_W]
- pm  out  NUM_STATES*PM_W  stored (normalised) metrics, same packing
- pm_valid  out  1  one-cycle pulse: pm updated by npm on the previous edge
- best_state  out  clog2(NUM_STATES)  index of minimum stored metric
- norm_event  out  1  one-cycle pulse: the last update applied a nonzero subtraction
- sat  out  1  sticky: some accepted npm lane equalled 2^PM_W-1

## Operation
- Reset (reset low, asynchronous): pm all 0, best_state 0, pm_valid 0, norm_event 0, sat 0.
- start high at an edge: pm lane 0 = 0, lanes 1.. = INIT_PEN; best_state 0; sat cleared; pm_valid 0, norm_event 0.
- start and npm_valid both high: start wins, npm is discarded.
- npm_valid high (no start): compute sub, then every lane pm[i] = npm[i] - sub.
- Mode 0: sub = min over all npm lanes. The result always contains at least one zero.
- Mode 1: sub = 2^(PM_W-1) if every npm lane MSB is 1, else 0.
- All arithmetic is unsigned, PM_W bits. The subtraction never underflows by construction. Inputs are not clipped.
- best_state = argmin of the post-subtraction lanes; ties resolve to the lowest index. It is registered with pm.
- norm_event = (sub != 0) for that update.
- sat is set if any accepted npm lane is all ones. It is cleared only by reset or start.
- npm_valid low: pm, best_state and sat hold; pm_valid and norm_event drop to 0.

## Timing
- Latency is 1 cycle. npm sampled at edge N appears on pm and best_state after edge N, and pm_valid is high for the cycle following edge N.
- Back-to-back npm_valid is accepted every cycle; there is no backpressure.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset asserted mid-stream clears immediately. The first accepted npm after deassertion is processed normally, with no warm-up cycle.
- Argmin tree plus subtractor must close in one cycle at NUM_STATES=64. No internal pipelining.

## Structure
- Shared package viterbi_pkg holds:
  - a clog2 function
  - NORM_MIN = 0, NORM_THRESH = 1 mode constants
  - the lane-packing helper convention
- Sub-module pm_min_tree: combinational, parametrised by NUM_STATES and PM_W. Returns the minimum value and its lowest index. It is instantiated once on npm for mode-0 sub, and reused on the subtracted lanes for best_state.

## Test plan
All scenarios use NUM_STATES=4, PM_W=4 unless noted.
- Reset then start: pm = {0,15,15,15}, best_state 0, sat 0, pm_valid 0.
- Mode 0, npm {2,3,5,9} valid: next cycle pm {0,1,3,7}, best_state 0, norm_event 1, pm_valid 1. Then npm {5,1,15,3}: pm {4,0,14,2}, best_state 1, sat 1 (sticky through later updates).
- Mode 1, npm {9,10,12,15}: pm {1,2,4,7}, norm_event 1. Then npm {2,3,5,9}: pm {2,3,5,9}, norm_event 0.
- Tie: mode 1, npm {6,3,3,7}: best_state 1. Then start and npm_valid together: start pattern loaded, npm dropped, pm_valid 0.
- Reset mid-stream with npm_valid held high: outputs clear asynchronously the same cycle. The first post-release update gives the correct pm_valid pulse.
- NUM_STATES=64, PM_W=8, mode 0 random streams vs reference model: min lane always 0, no lane wraps, argmin matches.
